// File: rtl/palette_dump.sv
// Palette RAM dump: reads ENTRIES 24-bit {R,G,B} words and streams them as bytes,
// R first, with out_addr = entry*3 + byte index.
module palette_dump #(
    parameter int ENTRIES = 256,
    parameter int ADDR_W  = 10
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [7:0]        pal_rd_addr,
    input  logic [23:0]       pal_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        dbg_state
);
    // Handshake: a byte transfers on a clk_sys edge where out_valid && out_ready;
    // while out_valid && !out_ready, out_data/out_addr hold and nothing advances.

    typedef enum logic [1:0] {IDLE, PRIME, SEND, FLUSH} state_t;

    localparam logic [7:0] LAST_ENTRY = 8'(ENTRIES - 1);

    state_t      state;
    logic [23:0] cur_word;
    logic [23:0] pf_word;
    logic        pf_full;
    logic        rd_req;
    logic        rd_req_d;
    logic [1:0]  byte_idx;
    logic [7:0]  cur_entry;
    logic        accept;

    assign accept    = out_valid && out_ready;
    assign dbg_state = state;

    // rd_req/rd_req_d track a read: address issued, RAM samples it, data usable.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            pal_rd_addr <= '0;
            cur_word    <= '0;
            pf_word     <= '0;
            pf_full     <= 1'b0;
            rd_req      <= 1'b0;
            rd_req_d    <= 1'b0;
            byte_idx    <= '0;
            cur_entry   <= '0;
        end else begin
            done     <= 1'b0;
            rd_req   <= 1'b0;
            rd_req_d <= rd_req;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                pf_full   <= 1'b0;
                rd_req    <= 1'b0;
                rd_req_d  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= PRIME;
                            busy        <= 1'b1;
                            pal_rd_addr <= '0;
                            rd_req      <= 1'b1;
                            pf_full     <= 1'b0;
                        end
                    end
                    PRIME: begin
                        if (rd_req_d) begin
                            cur_word  <= pal_rd_data;
                            out_data  <= pal_rd_data[23:16];
                            out_addr  <= '0;
                            out_valid <= 1'b1;
                            byte_idx  <= 2'd0;
                            cur_entry <= 8'd0;
                            state     <= SEND;
                            if (LAST_ENTRY != 8'd0) begin
                                pal_rd_addr <= 8'd1;
                                rd_req      <= 1'b1;
                            end
                        end
                    end
                    SEND: begin
                        if (rd_req_d && !pf_full) begin
                            pf_word <= pal_rd_data;
                            pf_full <= 1'b1;
                        end
                        if (accept) begin
                            if (byte_idx == 2'd2) begin
                                if (cur_entry == LAST_ENTRY) begin
                                    state     <= FLUSH;
                                    out_valid <= 1'b0;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                end else begin
                                    // The prefetch word is always full by now: it was
                                    // requested when the current entry was loaded.
                                    cur_word  <= pf_word;
                                    pf_full   <= 1'b0;
                                    out_data  <= pf_word[23:16];
                                    out_addr  <= out_addr + ADDR_W'(1);
                                    byte_idx  <= 2'd0;
                                    cur_entry <= cur_entry + 8'd1;
                                    if (cur_entry + 8'd1 < LAST_ENTRY) begin
                                        pal_rd_addr <= cur_entry + 8'd2;
                                        rd_req      <= 1'b1;
                                    end
                                end
                            end else begin
                                byte_idx <= byte_idx + 2'd1;
                                out_addr <= out_addr + ADDR_W'(1);
                                out_data <= (byte_idx == 2'd0) ? cur_word[15:8] : cur_word[7:0];
                            end
                        end
                    end
                    FLUSH: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_palette_dump.sv
// Bench for palette_dump: RAM model, randomized sink back-pressure, byte-stream
// reference built from the RAM contents, plus a 4-entry instance.
`timescale 1ns/1ps
module tb_palette_dump;
    localparam int ADDR_W = 10;
    localparam int W      = ADDR_W + 8;

    // clock / reset
    logic clk_sys = 1'b0;
    logic reset   = 1'b0;
    always #5 clk_sys = ~clk_sys;
    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // main instance (256 entries)
    logic              start = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic              busy, done, out_valid;
    logic [7:0]        pal_rd_addr, out_data;
    logic [23:0]       pal_rd_data;
    logic [ADDR_W-1:0] out_addr;
    logic [1:0]        dbg_state;

    palette_dump #(.ENTRIES(256), .ADDR_W(ADDR_W)) dut (
        .clk_sys(clk_sys), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .pal_rd_addr(pal_rd_addr), .pal_rd_data(pal_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .dbg_state(dbg_state)
    );

    // small instance (4 entries)
    logic        start4 = 1'b0, abort4 = 1'b0, ready4 = 1'b1;
    logic        busy4, done4, valid4;
    logic [7:0]  addr4, data4;
    logic [23:0] rdata4;
    logic [3:0]  oaddr4;
    logic [1:0]  st4;

    palette_dump #(.ENTRIES(4), .ADDR_W(4)) dut4 (
        .clk_sys(clk_sys), .reset(reset), .start(start4), .abort(abort4),
        .busy(busy4), .done(done4), .pal_rd_addr(addr4), .pal_rd_data(rdata4),
        .out_valid(valid4), .out_ready(ready4), .out_data(data4),
        .out_addr(oaddr4), .dbg_state(st4)
    );

    // palette RAM model: synchronous read, one cycle latency
    logic [23:0] mem [256];
    always @(posedge clk_sys) begin
        pal_rd_data <= mem[pal_rd_addr];
        rdata4      <= mem[addr4];
    end

    // scoreboard state
    int checks = 0, failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int start_cyc, first_valid_cyc, done_cyc, last_acc_cyc, stall_bad, extra_act;
    logic busy_at_done;
    int bad_idx;
    logic [W-1:0] bad_got, bad_exp;

    function automatic void fill_pattern();
        for (int n = 0; n < 256; n++) begin
            logic [7:0] b;
            b = 8'(n);
            mem[n] = {b, ~b, b ^ 8'h5A};
        end
    endfunction

    function automatic void fill_random();
        for (int n = 0; n < 256; n++) mem[n] = 24'($urandom);
    endfunction

    // Reference stream: entry e contributes bytes R,G,B at offsets 3e, 3e+1, 3e+2.
    function automatic void build_exp(input int n_entries);
        exp_q.delete();
        for (int e = 0; e < n_entries; e++)
            for (int b = 0; b < 3; b++)
                exp_q.push_back({ADDR_W'(e * 3 + b), 8'((mem[e] >> (8 * (2 - b))) & 24'hFF)});
    endfunction

    function automatic int seq_errors();
        int n;
        int lim;
        n = 0;
        lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        bad_idx = -1;
        bad_got = '0;
        bad_exp = '0;
        for (int i = 0; i < lim; i++) begin
            if (got_q[i] !== exp_q[i]) begin
                if (bad_idx < 0) begin
                    bad_idx = i;
                    bad_got = got_q[i];
                    bad_exp = exp_q[i];
                end
                n++;
            end
        end
        n += (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                           : exp_q.size() - got_q.size();
        return n;
    endfunction

    // driver tasks
    task automatic start_pulse();
        @(negedge clk_sys);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk_sys);
        start = 1'b0;
    endtask

    task automatic collect(input bit rand_ready, input int restart_a, input int restart_b);
        bit have_hold;
        logic [7:0] hold_d;
        logic [ADDR_W-1:0] hold_a;
        have_hold = 1'b0;
        hold_d = '0;
        hold_a = '0;
        got_q.delete();
        first_valid_cyc = -1;
        done_cyc = -1;
        last_acc_cyc = -1;
        stall_bad = 0;
        extra_act = 0;
        busy_at_done = 1'b1;
        for (int k = 0; k < 4000 && done_cyc < 0; k++) begin
            @(negedge clk_sys);
            if (have_hold && (!out_valid || out_data !== hold_d || out_addr !== hold_a)) stall_bad++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cyc = cyc;
                busy_at_done = busy;
            end
            out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            start = (cyc - start_cyc == restart_a) || (cyc - start_cyc == restart_b);
            have_hold = 1'b0;
            if (out_valid && out_ready) begin
                got_q.push_back({out_addr, out_data});
                last_acc_cyc = cyc;
            end else if (out_valid) begin
                have_hold = 1'b1;
                hold_d = out_data;
                hold_a = out_addr;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_sys);
            if (done || out_valid || busy) extra_act++;
        end
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({busy, done, out_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: busy/done/valid=%b need 000", {busy, done, out_valid});
        end
        checks++;
        if (out_data !== 8'h00 || out_addr !== '0) begin
            failures++;
            $display("FAIL reset_out: data=%h addr=%0d need 0/0", out_data, out_addr);
        end
        checks++;
        if (pal_rd_addr !== 8'h00 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_addr_state: rd_addr=%0d state=%0d need 0/0", pal_rd_addr, dbg_state);
        end
        checks++;
        if ({busy4, done4, valid4} !== 3'b000 || addr4 !== 8'h00 || oaddr4 !== 4'h0) begin
            failures++;
            $display("FAIL reset_small: flags=%b rd_addr=%0d addr=%0d need 0", {busy4, done4, valid4}, addr4, oaddr4);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_full_dump();
        int nbad;
        fill_pattern();
        build_exp(256);
        start_pulse();
        collect(1'b0, -1, -1);
        checks++;
        if (first_valid_cyc - start_cyc !== 3) begin
            failures++;
            $display("FAIL full_first_valid: latency=%0d need 3", first_valid_cyc - start_cyc);
        end
        nbad = seq_errors();
        checks++;
        if (nbad !== 0) begin
            failures++;
            $display("FAIL full_seq: %0d errors, first at %0d got %h need %h, count %0d need %0d",
                     nbad, bad_idx, bad_got, bad_exp, got_q.size(), exp_q.size());
        end
        checks++;
        if (done_cyc - start_cyc !== 771) begin
            failures++;
            $display("FAIL full_done_time: done at start+%0d need start+771", done_cyc - start_cyc);
        end
        checks++;
        if (busy_at_done !== 1'b0 || extra_act !== 0) begin
            failures++;
            $display("FAIL full_end: busy_at_done=%b extra_activity=%0d need 0/0", busy_at_done, extra_act);
        end
    endtask

    task automatic test_random_ready(input bit random_data);
        int nbad;
        if (random_data) fill_random(); else fill_pattern();
        build_exp(256);
        start_pulse();
        collect(1'b1, -1, -1);
        checks++;
        if (stall_bad !== 0) begin
            failures++;
            $display("FAIL stall_hold: %0d unstable stalled cycles, need 0", stall_bad);
        end
        nbad = seq_errors();
        checks++;
        if (nbad !== 0) begin
            failures++;
            $display("FAIL random_seq: %0d errors, first at %0d got %h need %h, count %0d need %0d",
                     nbad, bad_idx, bad_got, bad_exp, got_q.size(), exp_q.size());
        end
        checks++;
        if (done_cyc < 0 || done_cyc !== last_acc_cyc + 1 || extra_act !== 0) begin
            failures++;
            $display("FAIL random_done: done at %0d last accept %0d extra=%0d, need done=last+1, extra 0",
                     done_cyc, last_acc_cyc, extra_act);
        end
    endtask

    task automatic test_abort();
        bit found;
        int seen;
        int nbad;
        fill_pattern();
        build_exp(256);
        start_pulse();
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk_sys);
            if (out_valid && out_addr == ADDR_W'(31)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL abort_reach: byte 31 seen=%b need 1", found);
        end
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk_sys);
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL abort_stop: valid=%b busy=%b state=%0d need 0/0/0", out_valid, busy, dbg_state);
        end
        seen = 0;
        repeat (10) begin
            @(negedge clk_sys);
            if (done || out_valid || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_quiet: %0d active cycles after abort, need 0", seen);
        end
        start_pulse();
        collect(1'b0, -1, -1);
        nbad = seq_errors();
        checks++;
        if (nbad !== 0 || first_valid_cyc - start_cyc !== 3) begin
            failures++;
            $display("FAIL abort_redump: %0d errors first at %0d got %h need %h, latency %0d need 3",
                     nbad, bad_idx, bad_got, bad_exp, first_valid_cyc - start_cyc);
        end
    endtask

    task automatic test_restart_ignored();
        int nbad;
        fill_pattern();
        build_exp(256);
        start_pulse();
        collect(1'b0, 50, 400);
        nbad = seq_errors();
        checks++;
        if (nbad !== 0) begin
            failures++;
            $display("FAIL restart_seq: %0d errors, first at %0d got %h need %h, count %0d need 768",
                     nbad, bad_idx, bad_got, bad_exp, got_q.size());
        end
        checks++;
        if (done_cyc - start_cyc !== 771 || extra_act !== 0) begin
            failures++;
            $display("FAIL restart_done: done at start+%0d extra=%0d need start+771, 0", done_cyc - start_cyc, extra_act);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        int nbad;
        fill_pattern();
        build_exp(256);
        start_pulse();
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk_sys);
            if (out_valid && out_addr == ADDR_W'(300)) found = 1'b1;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (!found || {busy, done, out_valid} !== 3'b000 || out_data !== 8'h00 ||
            out_addr !== '0 || pal_rd_addr !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: reached=%b flags=%b data=%h addr=%0d rd_addr=%0d need 1,000,0,0,0",
                     found, {busy, done, out_valid}, out_data, out_addr, pal_rd_addr);
        end
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (dbg_state !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_idle: state=%0d busy=%b need 0/0", dbg_state, busy);
        end
        start_pulse();
        collect(1'b0, -1, -1);
        nbad = seq_errors();
        checks++;
        if (nbad !== 0) begin
            failures++;
            $display("FAIL async_redump: %0d errors, first at %0d got %h need %h", nbad, bad_idx, bad_got, bad_exp);
        end
    endtask

    task automatic test_entries4();
        int max_addr, d4, last4, nbad;
        fill_random();
        build_exp(4);
        got_q.delete();
        @(negedge clk_sys);
        start4 = 1'b1;
        @(negedge clk_sys);
        start4 = 1'b0;
        max_addr = 0;
        d4 = -1;
        last4 = -1;
        for (int k = 0; k < 200 && d4 < 0; k++) begin
            @(negedge clk_sys);
            if (int'(addr4) > max_addr) max_addr = int'(addr4);
            if (done4) d4 = cyc;
            ready4 = 1'($urandom_range(0, 1));
            if (valid4 && ready4) begin
                got_q.push_back({6'd0, oaddr4, data4});
                last4 = cyc;
            end
        end
        ready4 = 1'b1;
        nbad = seq_errors();
        checks++;
        if (nbad !== 0) begin
            failures++;
            $display("FAIL small_seq: %0d errors, first at %0d got %h need %h, count %0d need 12",
                     nbad, bad_idx, bad_got, bad_exp, got_q.size());
        end
        checks++;
        if (max_addr > 3) begin
            failures++;
            $display("FAIL small_rd_addr: max rd addr %0d need <= 3", max_addr);
        end
        checks++;
        if (d4 < 0 || d4 !== last4 + 1) begin
            failures++;
            $display("FAIL small_done: done at %0d last accept %0d need last+1", d4, last4);
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_random_ready(1'b0);
        test_random_ready(1'b1);
        test_abort();
        test_restart_ignored();
        test_async_reset();
        test_entries4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
